mux_frame_decoder: RTL
======================

# mux_frame_decoder

Receive-side decoder for the 5-bit digit stream produced by the digit-select multiplexer. A word with bit 4 = 0 marks the common/start slot, and the next three words carry bit 4 = 1. The block finds the start word and rebuilds the four 4-bit digit values of one frame. It delivers them as one parallel, registered update, and reports frame errors and gaps. It sits at the receiving end of the link, in front of display or compare logic.

## Interface
Parameters:
- GAP_MAX, 15: most idle cycles allowed between valid words inside a frame before the frame is aborted (width 4).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- din  input  5  stream word; din[4] = slot flag (0 = start/COM slot, 1 = data slot), din[3:0] = digit.
- din_valid  input  1  din is sampled only when this is 1.
- q1, q2, q3, q4  output  4 each  last complete frame's digits, in stream order.
- frame_valid  output  1  one-cycle pulse when q1..q4 update.
- sync_err  output  1  one-cycle pulse on any frame abort.
- locked  output  1  high after a good frame; low after any abort or reset.
- err_count  output  ERR_W  count of aborts; saturates at all-ones.

## Operation
- FSM states: HUNT, S1, S2, S3. Shadow registers sh1, sh2, sh3 hold partial frame data. The gap counter gap_cnt is 4 bits.
- HUNT:
  - Valid word with flag 0: sh1 <= din[3:0], go to S1.
  - Valid word with flag 1: discarded silently. This is not an error.
- S1: valid word with flag 1 gives sh2 <= digit and go to S2.
- S2: valid word with flag 1 gives sh3 <= digit and go to S3.
- S3: valid word with flag 1 commits the frame:
  - q1 <= sh1, q2 <= sh2, q3 <= sh3, q4 <= digit.
  - frame_valid <= 1, locked <= 1, go to HUNT.
- Flag 0 received in S1, S2 or S3 (premature start):
  - Abort: sync_err <= 1, err_count increments (saturating), locked <= 0.
  - The same word is taken as a new start: sh1 <= digit, go to S1. No word is lost.
- Gap rule, in S1, S2 or S3:
  - gap_cnt clears on every valid word and increments on each cycle with din_valid = 0.
  - When gap_cnt = GAP_MAX and din_valid = 0: abort (sync_err, err_count++, locked <= 0), go to HUNT, clear gap_cnt.
  - In HUNT, gap_cnt is held at 0.
- q1..q4 change only on commit. Aborted frames never reach the outputs.
- err_count at all-ones stays there. sync_err still pulses.
- Reset (rst_n = 0 at an edge), at any time including mid-frame:
  - state = HUNT; q1..q4 = 0; sh1..sh3 = 0; frame_valid = 0; sync_err = 0; locked = 0; err_count = 0; gap_cnt = 0.
  - The partial frame is dropped. No sync_err is raised for it.

## Timing
- All outputs are registered.
- frame_valid is high for the one cycle after the edge that samples the 4th word.
- q1..q4 take their new values on that same edge and hold until the next commit.
- sync_err and the err_count update appear the cycle after the edge that samples the offending word or reaches the timeout.
- Back-to-back frames, with din_valid held high, give one frame_valid every 4 cycles.
- din is don't-care when din_valid = 0.
- A premature start plus a restart in the same cycle gives a single sync_err pulse, and the FSM goes to S1.

## Test plan
- Reset, then stream 0x03, 0x15, 0x17, 0x19 with valid held high:
  - Response: q1..q4 = 3, 5, 7, 9; frame_valid pulses once, 1 cycle after the 4th word; locked = 1; err_count = 0.
- Stream 0x11, 0x12 while in HUNT, then a good frame 0x00, 0x11, 0x12, 0x13:
  - Response: no sync_err from the leading words; q = 0, 1, 2, 3.
- Stream 0x04, 0x16, then 0x08, 0x1A, 0x1B, 0x1C:
  - Response: one sync_err at the 0x08 word; err_count = 1; q = 8, A, B, C; locked = 1 after the commit.
- Stream 0x05, 0x16, then din_valid = 0 for 16 cycles, then 0x17:
  - Response: abort after 16 idle cycles (gap_cnt reached 15 plus one more idle cycle); FSM in HUNT; 0x17 is ignored; q unchanged.
- Stream 0x01, 0x12, then pull rst_n low for 1 cycle, then 0x1F:
  - Response: all outputs 0; no frame_valid or sync_err; 0x1F is discarded.
- Force 260 premature-start aborts with ERR_W = 8:
  - Response: err_count stops at 255; sync_err pulses 260 times.

Source files
------------

// File: rtl/mux_frame_decoder.sv
// mux_frame_decoder: rebuilds 4-digit frames from a 5-bit slot-flagged digit stream
module mux_frame_decoder #(
  parameter logic [3:0] GAP_MAX = 4'd15,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       din,
  input  logic             din_valid,
  output logic [3:0]       q1,
  output logic [3:0]       q2,
  output logic [3:0]       q3,
  output logic [3:0]       q4,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S2   = 2'd2;
  localparam logic [1:0] S3   = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [3:0]       sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [3:0]       q1_q, q1_d, q2_q, q2_d, q3_q, q3_d, q4_q, q4_d;
  logic [3:0]       gap_q, gap_d;
  logic             fv_q, fv_d, se_q, se_d, lock_q, lock_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             start, data, in_frame, timeout, abort, commit;
  assign start    = din_valid & ~din[4];
  assign data     = din_valid & din[4];
  assign in_frame = state_q != HUNT;
  assign timeout  = in_frame & ~din_valid & (gap_q == GAP_MAX);
  // A start word inside a frame aborts it but is still kept as the new start.
  assign abort    = (in_frame & start) | timeout;
  assign commit   = (state_q == S3) & data;
  // Next-state: slot sequencing, shadow capture, commit and error bookkeeping
  always_comb begin
    state_d = start ? S1 : timeout ? HUNT : (data & in_frame) ? ((state_q == S3) ? HUNT : state_q + 2'd1) : state_q;
    gap_d   = (!in_frame || din_valid || timeout) ? 4'd0 : gap_q + 4'd1;
    sh1_d   = start ? din[3:0] : sh1_q;
    sh2_d   = (data && state_q == S1) ? din[3:0] : sh2_q;
    sh3_d   = (data && state_q == S2) ? din[3:0] : sh3_q;
    q1_d    = commit ? sh1_q : q1_q;
    q2_d    = commit ? sh2_q : q2_q;
    q3_d    = commit ? sh3_q : q3_q;
    q4_d    = commit ? din[3:0] : q4_q;
    fv_d    = commit;
    se_d    = abort;
    lock_d  = abort ? 1'b0 : commit ? 1'b1 : lock_q;
    err_d   = (abort && !(&err_q)) ? err_q + 1'b1 : err_q;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      gap_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      q3_q    <= '0;
      q4_q    <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      sh3_q   <= sh3_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      q3_q    <= q3_d;
      q4_q    <= q4_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end
  assign q1          = q1_q;
  assign q2          = q2_q;
  assign q3          = q3_q;
  assign q4          = q4_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = lock_q;
  assign err_count   = err_q;
endmodule
